decoder_64b66b: RTL and testbench
=================================

# decoder_64b66b

Receive-side counterpart of the 64b/66b scrambling coder. It accepts raw 66-bit blocks from the RX gearbox, checks the 2-bit sync header, and maintains block lock with a bitslip request back to the gearbox. It descrambles the 64-bit payload with the self-synchronizing polynomial G(x) = 1 + x^39 + x^58 and forwards locked blocks downstream as {ttype, data} on AXI Stream.

## Interface
- SH_CNT_LOCK, 64: consecutive valid headers required to acquire lock; also the size of the locked monitoring window.
- SH_INVLD_MAX, 16: invalid headers within one locked window that force loss of lock.
- SLIP_WAIT, 2: accepted blocks ignored after each bitslip pulse, to absorb gearbox realignment latency.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  66  [65:64] sync header, [63:0] scrambled payload; bit 0 is the first transmitted payload bit.
- s_axis_tvalid  in  1  input block valid.
- s_axis_tready  out  1  equals m_axis_tready, combinational.
- m_axis_ttype  out  2  received sync header (2'b01 = data, 2'b10 = control, 00/11 = invalid).
- m_axis_tdata  out  64  descrambled payload.
- m_axis_tuser  out  1  set when the header of this block is invalid (00 or 11).
- m_axis_tvalid  out  1  output block valid.
- m_axis_tready  in  1  downstream ready.
- block_lock  out  1  block lock status.
- bitslip  out  1  one-cycle request to the gearbox to shift alignment by one bit.

## Operation
- Accept: a block is accepted when s_axis_tvalid && s_axis_tready.
- Descrambler:
  - Keep a 64-bit history H of the previous accepted scrambled payload.
  - Form C = {s_axis_tdata[63:0], H} (128 bits).
  - For i in 0..63: d[i] = C[64+i] ^ C[64+i-39] ^ C[64+i-58].
  - On every accepted block, H <= s_axis_tdata[63:0]. This applies whatever the lock state, header validity or slip wait.
- Header check: valid when s_axis_tdata[65:64] is 01 or 10.
- Lock FSM, with counters sh_cnt and sh_invld_cnt. The FSM advances only on accepted blocks.
  - TEST (block_lock=0):
    - Valid header: sh_cnt++.
    - When sh_cnt reaches SH_CNT_LOCK: go to LOCKED, block_lock <= 1, clear both counters.
    - Invalid header: pulse bitslip, clear counters, go to SLIP.
  - SLIP (block_lock=0):
    - Count SLIP_WAIT accepted blocks without checking their headers, then go to TEST with counters cleared.
  - LOCKED (block_lock=1):
    - Every block: sh_cnt++. Invalid header: sh_invld_cnt++.
    - When sh_invld_cnt reaches SH_INVLD_MAX: block_lock <= 0, pulse bitslip, clear counters, go to SLIP.
    - Otherwise, when sh_cnt reaches SH_CNT_LOCK: clear both counters and stay in LOCKED (window restart).
    - If the invalid limit and the window end occur on the same block, loss of lock wins.
- Forwarding:
  - An accepted block is forwarded only if the FSM is in LOCKED when the block is accepted (pre-update state).
  - The block that completes acquisition is not forwarded.
  - The block that triggers loss of lock is forwarded with m_axis_tuser=1.
  - Non-forwarded accepted blocks are consumed and dropped.
- Counter widths: sized to hold SH_CNT_LOCK and SH_INVLD_MAX without wrap.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_ttype=0, m_axis_tuser=0.
  - block_lock=0, bitslip=0.
  - FSM in TEST, counters 0, H=0.
- Latency: 1 cycle from acceptance to the registered output.
- Output update:
  - When m_axis_tready=1: m_axis_tvalid <= (s_axis_tvalid && LOCKED).
  - Data, ttype and tuser load on acceptance of a forwarded block.
- Stall: when m_axis_tready=0, all outputs, H, FSM and counters hold. No block is accepted.
- block_lock and bitslip are registered and change in the cycle after the triggering block is accepted. bitslip is high for exactly one cycle per event.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous). After release, the block must re-acquire lock from TEST.

## Test plan
- Reset, then 64 accepted blocks with header 01 and payload 0 -> block_lock rises the cycle after block 64; no output for blocks 1–64; block 65 is output with m_axis_ttype=01, m_axis_tdata=0.
- While locked with H=0, send scrambled payload 64'h1 -> m_axis_tdata=64'h0400_0080_0000_0001; the next block with payload 0 yields bits 39+0 and 58+0 shifted, i.e. 64'h0 ^ history terms, and this is checked against the model.
- Loopback from the 64b66b coder with random data and ttype, after lock -> output equals coder input exactly, 1-cycle latency, no drops.
- Unlocked, header 11 on block 10 -> bitslip pulse for 1 cycle; next 2 blocks ignored; 64 further valid headers are needed to lock.
- Locked, 16 invalid headers (00) inside one 64-block window -> block_lock falls after the 16th, that block is output with tuser=1, bitslip pulses. With 15 invalid headers, lock is held and the window restarts.
- m_axis_tready toggled randomly during lock, and reset_n asserted mid-stream -> no loss or duplication under backpressure; after reset, all outputs are 0 and block_lock=0 until re-acquired.

Source files
------------

// File: rtl/decoder_64b66b.sv
// ---------------------------------------------------------------------------
// decoder_64b66b
//
// Receive side of the 64b/66b line code. Raw 66-bit blocks arrive from the RX
// gearbox. The 2-bit sync header is checked to gain and keep block lock, and
// a one-cycle bitslip request is sent back to the gearbox while hunting for
// alignment. The payload is descrambled with the self-synchronizing
// polynomial G(x) = 1 + x^39 + x^58. Blocks received while locked are
// forwarded downstream as {ttype, data} on AXI Stream.
//
// Ports
//   clk            single clock
//   reset_n        asynchronous, active-low reset
//   s_axis_tdata   [65:64] sync header, [63:0] scrambled payload (bit 0 first)
//   s_axis_tvalid  input block valid
//   s_axis_tready  input ready; a copy of m_axis_tready
//   m_axis_ttype   received sync header (01 data, 10 control, 00/11 invalid)
//   m_axis_tdata   descrambled payload
//   m_axis_tuser   set when the header of this block is invalid
//   m_axis_tvalid  output block valid
//   m_axis_tready  downstream ready
//   block_lock     block lock status
//   bitslip        one-cycle request to shift gearbox alignment by one bit
// ---------------------------------------------------------------------------
module decoder_64b66b #(
    parameter int SH_CNT_LOCK  = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [65:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [1:0]  m_axis_ttype,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        block_lock,
    output logic        bitslip
);

    // Counter widths hold the terminal value without wrapping; never below 1.
    localparam int CNT_W  = (SH_CNT_LOCK  < 1) ? 1 : $clog2(SH_CNT_LOCK + 1);
    localparam int INV_W  = (SH_INVLD_MAX < 1) ? 1 : $clog2(SH_INVLD_MAX + 1);
    localparam int SLIP_W = (SLIP_WAIT    < 1) ? 1 : $clog2(SLIP_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LOCK  = CNT_W'(SH_CNT_LOCK);
    localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(SH_INVLD_MAX);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_TEST,
        ST_SLIP,
        ST_LOCKED
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   sh_cnt;
    logic [INV_W-1:0]   sh_invld_cnt;
    logic [SLIP_W-1:0]  slip_cnt;
    logic [63:0]        hist;

    logic               accept;
    logic [1:0]         header;
    logic               header_ok;
    logic [63:0]        descrambled;
    logic [CNT_W-1:0]   sh_cnt_inc;
    logic [INV_W-1:0]   invld_inc;
    logic [SLIP_W-1:0]  slip_inc;

    // The input side can only move when the output side can, so every stall
    // freezes the whole pipeline together.
    assign s_axis_tready = m_axis_tready;
    assign accept        = s_axis_tvalid && m_axis_tready;
    assign header        = s_axis_tdata[65:64];
    assign header_ok     = (header == 2'b01) || (header == 2'b10);

    assign sh_cnt_inc = sh_cnt + CNT_W'(1);
    assign invld_inc  = header_ok ? sh_invld_cnt : (sh_invld_cnt + INV_W'(1));
    assign slip_inc   = slip_cnt + SLIP_W'(1);

    // Descrambler: each output bit is the received bit XOR the received bits
    // 39 and 58 positions earlier in the serial stream. Concatenating the
    // current payload above the previous one lets the taps reach back across
    // the block boundary: bit 64+i is the current bit, 25+i and 6+i the taps.
    always_comb begin
        logic [127:0] stream;
        stream      = {s_axis_tdata[63:0], hist};
        descrambled = '0;
        for (int i = 0; i < 64; i++) begin
            descrambled[i] = stream[64 + i] ^ stream[25 + i] ^ stream[6 + i];
        end
    end

    // Lock state machine, descrambler history and registered output stage.
    // bitslip is a strobe: it drops back to zero on the cycle after any pulse,
    // even if the stream stalls, so the gearbox sees exactly one request.
    // Forwarding is decided on the state before the update, so the block
    // that completes acquisition is dropped while the block that loses lock
    // is still forwarded (flagged through tuser by its bad header).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_TEST;
            sh_cnt        <= '0;
            sh_invld_cnt  <= '0;
            slip_cnt      <= '0;
            hist          <= '0;
            block_lock    <= 1'b0;
            bitslip       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_ttype  <= '0;
            m_axis_tuser  <= 1'b0;
        end else begin
            bitslip <= 1'b0;

            if (m_axis_tready) begin
                m_axis_tvalid <= s_axis_tvalid && (state == ST_LOCKED);
            end

            if (accept) begin
                hist <= s_axis_tdata[63:0];

                if (state == ST_LOCKED) begin
                    m_axis_tdata <= descrambled;
                    m_axis_ttype <= header;
                    m_axis_tuser <= !header_ok;
                end

                case (state)
                    ST_TEST: begin
                        if (!header_ok) begin
                            bitslip      <= 1'b1;
                            sh_cnt       <= '0;
                            sh_invld_cnt <= '0;
                            slip_cnt     <= '0;
                            state        <= ST_SLIP;
                        end else if (sh_cnt_inc >= CNT_LOCK) begin
                            block_lock   <= 1'b1;
                            sh_cnt       <= '0;
                            sh_invld_cnt <= '0;
                            state        <= ST_LOCKED;
                        end else begin
                            sh_cnt <= sh_cnt_inc;
                        end
                    end

                    ST_SLIP: begin
                        // Headers are not examined here; the gearbox may
                        // still be delivering blocks at the old alignment.
                        if (slip_inc >= SLIP_LAST) begin
                            sh_cnt       <= '0;
                            sh_invld_cnt <= '0;
                            slip_cnt     <= '0;
                            state        <= ST_TEST;
                        end else begin
                            slip_cnt <= slip_inc;
                        end
                    end

                    ST_LOCKED: begin
                        // Loss of lock takes priority over a window restart
                        // landing on the same block.
                        if (invld_inc >= INV_MAX) begin
                            block_lock   <= 1'b0;
                            bitslip      <= 1'b1;
                            sh_cnt       <= '0;
                            sh_invld_cnt <= '0;
                            slip_cnt     <= '0;
                            state        <= ST_SLIP;
                        end else if (sh_cnt_inc >= CNT_LOCK) begin
                            sh_cnt       <= '0;
                            sh_invld_cnt <= '0;
                        end else begin
                            sh_cnt       <= sh_cnt_inc;
                            sh_invld_cnt <= invld_inc;
                        end
                    end

                    default: begin
                        state <= ST_TEST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_64b66b.sv
// ---------------------------------------------------------------------------
// tb_decoder_64b66b
//
// Self-checking bench for decoder_64b66b. A behavioural reference model keeps
// the received bit stream serially (a 58-bit delay line) and tracks lock with
// plain run/window counters. Each scenario task drives stimulus and compares
// the DUT outputs against the model and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_decoder_64b66b;

    localparam int LOCK_N = 64;
    localparam int INV_N  = 16;
    localparam int WAIT_N = 2;

    logic        clk;
    logic        reset_n;
    logic [65:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [1:0]  m_axis_ttype;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        block_lock;
    logic        bitslip;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit          m_locked;
    int          m_run;
    int          m_slip_left;
    int          m_win_pos;
    int          m_win_bad;
    bit          rx_hist[$];
    bit          tx_hist[$];
    int          fwd_count = 0;
    int          out_xfers = 0;

    logic        e_valid;
    logic        e_user;
    logic [1:0]  e_type;
    logic [63:0] e_data;
    logic        e_lock;
    logic        e_slip;

    decoder_64b66b #(
        .SH_CNT_LOCK (LOCK_N),
        .SH_INVLD_MAX(INV_N),
        .SLIP_WAIT   (WAIT_N)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_ttype (m_axis_ttype),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .block_lock   (block_lock),
        .bitslip      (bitslip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output handshakes seen at the DUT, used for loss/duplication checks.
    always @(posedge clk) begin
        if (reset_n && m_axis_tvalid && m_axis_tready) out_xfers++;
    end

    task automatic model_reset();
        m_locked    = 1'b0;
        m_run       = 0;
        m_slip_left = 0;
        m_win_pos   = 0;
        m_win_bad   = 0;
        rx_hist.delete();
        for (int i = 0; i < 58; i++) rx_hist.push_back(1'b0);
        e_valid = 1'b0;
        e_user  = 1'b0;
        e_type  = 2'b00;
        e_data  = 64'h0;
        e_lock  = 1'b0;
        e_slip  = 1'b0;
    endtask

    // Serial descrambler: out = in ^ in(t-39) ^ in(t-58), bit 0 first.
    // rx_hist[0] is the bit 58 places back, rx_hist[19] the one 39 back.
    task automatic rx_descramble(input logic [63:0] p, output logic [63:0] d);
        for (int i = 0; i < 64; i++) begin
            d[i] = p[i] ^ rx_hist[19] ^ rx_hist[0];
            rx_hist.push_back(p[i]);
            void'(rx_hist.pop_front());
        end
    endtask

    // Serial scrambler matching the far-end coder: s = d ^ s(t-39) ^ s(t-58).
    task automatic tx_scramble(input logic [63:0] d, output logic [63:0] s);
        for (int i = 0; i < 64; i++) begin
            s[i] = d[i] ^ tx_hist[19] ^ tx_hist[0];
            tx_hist.push_back(s[i]);
            void'(tx_hist.pop_front());
        end
    endtask

    // Advance the model by the block currently presented at the inputs.
    task automatic model_step();
        logic        acc;
        logic [1:0]  hdr;
        logic        ok;
        logic [63:0] dd;
        acc    = s_axis_tvalid && m_axis_tready;
        e_slip = 1'b0;
        if (m_axis_tready) e_valid = s_axis_tvalid && m_locked;
        if (acc) begin
            hdr = s_axis_tdata[65:64];
            ok  = (hdr == 2'b01) || (hdr == 2'b10);
            rx_descramble(s_axis_tdata[63:0], dd);
            if (m_locked) begin
                e_data = dd;
                e_type = hdr;
                e_user = !ok;
                fwd_count++;
                m_win_pos++;
                if (!ok) m_win_bad++;
                if (m_win_bad == INV_N) begin
                    m_locked    = 1'b0;
                    e_slip      = 1'b1;
                    m_slip_left = WAIT_N;
                    m_run       = 0;
                    m_win_pos   = 0;
                    m_win_bad   = 0;
                end else if (m_win_pos == LOCK_N) begin
                    m_win_pos = 0;
                    m_win_bad = 0;
                end
            end else if (m_slip_left > 0) begin
                m_slip_left--;
            end else if (ok) begin
                m_run++;
                if (m_run == LOCK_N) begin
                    m_locked  = 1'b1;
                    m_run     = 0;
                    m_win_pos = 0;
                    m_win_bad = 0;
                end
            end else begin
                e_slip      = 1'b1;
                m_slip_left = WAIT_N;
                m_run       = 0;
            end
        end
        e_lock = m_locked;
    endtask

    // Present one cycle of inputs, update the model, then sample 1 ns after
    // the rising edge.
    task automatic drive(input logic v, input logic [1:0] h, input logic [63:0] p,
                         input logic rdy);
        s_axis_tvalid = v;
        s_axis_tdata  = {h, p};
        m_axis_tready = rdy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip} !== 6'b0 ||
            m_axis_tdata !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v/u/t/l/s=%b data=%h, want 000000 data=0",
                     {m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip}, m_axis_tdata);
        end
        m_axis_tready = 1'b0;
        #1;
        vectors++;
        if (s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tready_follow0: got %b want 0", s_axis_tready);
        end
        m_axis_tready = 1'b1;
        #1;
        vectors++;
        if (s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tready_follow1: got %b want 1", s_axis_tready);
        end
    endtask

    // 64 valid headers with zero payload; lock rises after the 64th, nothing
    // is forwarded until block 65.
    task automatic test_acquire();
        for (int k = 1; k <= LOCK_N; k++) begin
            drive(1'b1, 2'b01, 64'h0, 1'b1);
            vectors++;
            if ({m_axis_tvalid, block_lock, bitslip} !== {1'b0, (k == LOCK_N), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL acquire_blk%0d: got valid/lock/slip=%b want %b", k,
                         {m_axis_tvalid, block_lock, bitslip}, {1'b0, (k == LOCK_N), 1'b0});
            end
        end
        drive(1'b1, 2'b01, 64'h0, 1'b1);
        vectors++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_ttype} !== 4'b1001 || m_axis_tdata !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL acquire_blk65: got v/u/t=%b data=%h want 1001 data=0",
                     {m_axis_tvalid, m_axis_tuser, m_axis_ttype}, m_axis_tdata);
        end
    endtask

    // Single set bit against zero history, then model-checked random blocks.
    task automatic test_descramble();
        drive(1'b1, 2'b01, 64'h1, 1'b1);
        vectors++;
        if (m_axis_tdata !== 64'h0400_0080_0000_0001 || m_axis_tvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL descr_impulse: got v=%b data=%h want 1 data=0400008000000001",
                     m_axis_tvalid, m_axis_tdata);
        end
        for (int k = 0; k < 12; k++) begin
            logic [63:0] p;
            p = (k == 0) ? 64'h0 : {$urandom, $urandom};
            drive(1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, p, 1'b1);
            vectors++;
            if ({m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip} !==
                {e_valid, e_user, e_type, e_lock, e_slip} || m_axis_tdata !== e_data) begin
                miscompares++;
                $display("[TB] FAIL descr_blk%0d: got v/u/t/l/s=%b data=%h want %b data=%h", k,
                         {m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip},
                         m_axis_tdata, {e_valid, e_user, e_type, e_lock, e_slip}, e_data);
            end
        end
    endtask

    // Far-end scrambler in the bench feeding the DUT: output must equal the
    // original data and ttype, one cycle after each block.
    task automatic test_loopback();
        tx_hist = rx_hist;
        for (int k = 0; k < 40; k++) begin
            logic [63:0] d;
            logic [63:0] s;
            logic [1:0]  t;
            d = {$urandom, $urandom};
            t = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            tx_scramble(d, s);
            drive(1'b1, t, s, 1'b1);
            vectors++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_ttype !== t ||
                m_axis_tuser !== 1'b0 || block_lock !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL loopback_blk%0d: got v=%b t=%b data=%h lock=%b want 1 %b %h 1",
                         k, m_axis_tvalid, m_axis_ttype, m_axis_tdata, block_lock, t, d);
            end
        end
    endtask

    // Header 11 on block 10 while hunting: one bitslip pulse, two ignored
    // blocks, then a full run of 64 valid headers to lock.
    task automatic test_bitslip();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, (k == 10) ? 2'b11 : 2'b01, {$urandom, $urandom}, 1'b1);
        end
        vectors++;
        if ({bitslip, block_lock} !== 2'b10 || e_slip !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL slip_pulse: got slip/lock=%b want 10", {bitslip, block_lock});
        end
        for (int k = 0; k < WAIT_N; k++) begin
            drive(1'b1, (k == 0) ? 2'b00 : 2'b11, {$urandom, $urandom}, 1'b1);
            vectors++;
            if ({bitslip, block_lock, m_axis_tvalid} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL slip_wait%0d: got slip/lock/valid=%b want 000", k,
                         {bitslip, block_lock, m_axis_tvalid});
            end
        end
        for (int k = 1; k <= LOCK_N; k++) begin
            drive(1'b1, 2'b10, {$urandom, $urandom}, 1'b1);
            vectors++;
            if ({block_lock, bitslip, m_axis_tvalid} !== {(k == LOCK_N), 1'b0, 1'b0} ||
                block_lock !== e_lock) begin
                miscompares++;
                $display("[TB] FAIL relock_blk%0d: got lock/slip/valid=%b want %b", k,
                         {block_lock, bitslip, m_axis_tvalid}, {(k == LOCK_N), 1'b0, 1'b0});
            end
        end
    endtask

    // 15 bad headers in one window keep lock; 16 in the next window lose it.
    task automatic test_loss();
        do_reset();
        for (int k = 0; k < LOCK_N; k++) drive(1'b1, 2'b01, {$urandom, $urandom}, 1'b1);
        for (int k = 0; k < LOCK_N; k++) begin
            drive(1'b1, (k % 4 == 0 && k < 60) ? 2'b00 : 2'b01, {$urandom, $urandom}, 1'b1);
            vectors++;
            if (block_lock !== 1'b1 || bitslip !== 1'b0 || m_axis_tdata !== e_data ||
                m_axis_tuser !== e_user) begin
                miscompares++;
                $display("[TB] FAIL hold15_blk%0d: got lock/slip/user=%b data=%h want 10%b data=%h",
                         k, {block_lock, bitslip, m_axis_tuser}, m_axis_tdata, e_user, e_data);
            end
        end
        for (int k = 0; k < 46; k++) begin
            drive(1'b1, (k % 3 == 0) ? 2'b00 : 2'b10, {$urandom, $urandom}, 1'b1);
            vectors++;
            if (k < 45 && block_lock !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL early_loss_blk%0d: got lock=%b want 1", k, block_lock);
            end
        end
        vectors++;
        if ({block_lock, bitslip, m_axis_tvalid, m_axis_tuser, m_axis_ttype} !== 6'b011100 ||
            m_axis_tdata !== e_data) begin
            miscompares++;
            $display("[TB] FAIL loss16: got lock/slip/v/u/t=%b data=%h want 011100 data=%h",
                     {block_lock, bitslip, m_axis_tvalid, m_axis_tuser, m_axis_ttype},
                     m_axis_tdata, e_data);
        end
        drive(1'b1, 2'b01, {$urandom, $urandom}, 1'b1);
        vectors++;
        if ({block_lock, bitslip, m_axis_tvalid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL after_loss: got lock/slip/valid=%b want 000",
                     {block_lock, bitslip, m_axis_tvalid});
        end
    endtask

    // Random valid/ready while locked, then reset mid-stream.
    task automatic test_back_to_back();
        int fwd_start;
        int xfer_start;
        do_reset();
        for (int k = 0; k < LOCK_N; k++) drive(1'b1, 2'b01, {$urandom, $urandom}, 1'b1);
        fwd_start  = fwd_count;
        xfer_start = out_xfers;
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01,
                  {$urandom, $urandom}, $urandom_range(0, 4) < 3);
            vectors++;
            if ({m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip} !==
                {e_valid, e_user, e_type, e_lock, e_slip} || m_axis_tdata !== e_data) begin
                miscompares++;
                $display("[TB] FAIL bp_cyc%0d: got v/u/t/l/s=%b data=%h want %b data=%h", k,
                         {m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip},
                         m_axis_tdata, {e_valid, e_user, e_type, e_lock, e_slip}, e_data);
            end
        end
        drive(1'b0, 2'b01, 64'h0, 1'b1);
        drive(1'b0, 2'b01, 64'h0, 1'b1);
        vectors++;
        if ((out_xfers - xfer_start) !== (fwd_count - fwd_start) || fwd_count == fwd_start) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d transfers want %0d",
                     out_xfers - xfer_start, fwd_count - fwd_start);
        end
        for (int k = 0; k < 5; k++) drive(1'b1, 2'b01, {$urandom, $urandom}, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip} !== 6'b0 ||
            m_axis_tdata !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset: got v/u/t/l/s=%b data=%h want 000000 data=0",
                     {m_axis_tvalid, m_axis_tuser, m_axis_ttype, block_lock, bitslip}, m_axis_tdata);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 2'b01, {$urandom, $urandom}, 1'b1);
            vectors++;
            if ({block_lock, m_axis_tvalid} !== 2'b00 || block_lock !== e_lock) begin
                miscompares++;
                $display("[TB] FAIL post_reset_blk%0d: got lock/valid=%b want 00", k,
                         {block_lock, m_axis_tvalid});
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        model_reset();
        test_reset();
        test_acquire();
        test_descramble();
        test_loopback();
        test_bitslip();
        test_loss();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
